// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a framed program image byte-by-byte, packs it into 32-bit words,
// writes them to program RAM and releases the CPU reset after a good checksum. Option: BOOT_TIMEOUT_EN.
module uart_boot_loader #(
    parameter int ADDR_WIDTH     = 10,
    parameter int BASE_ADDR      = 0,
    parameter int MAX_WORDS      = 1024,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  mem_stb,
    output logic [ADDR_WIDTH-1:0] mem_adr,
    output logic [31:0]           mem_dat,
    input  logic                  mem_ack,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DRAIN, S_DONE, S_ERROR
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    state_t      state, next_state;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_buf;
    logic [7:0]  sum;
    logic        tx_acked;
    logic [15:0] len_full;
    logic        in_frame;
    logic        timed_out;
    logic        issue_write;
    logic        err_set;
    logic [1:0]  err_val;

    assign len_full = {rx_data, len_lo};
    assign in_frame = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA) || (state == S_CSUM);

`ifdef BOOT_TIMEOUT_EN
    logic [31:0] idle_cnt;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            idle_cnt <= '0;
        else if (rx_valid || !in_frame)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + 32'd1;
    end

    assign timed_out = in_frame && (idle_cnt >= 32'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state  = state;
        issue_write = 1'b0;
        err_set     = 1'b0;
        err_val     = 2'd0;
        case (state)
            S_IDLE:  if (rx_valid && rx_data == SYNC_BYTE) next_state = S_LEN0;
            S_LEN0:  if (rx_valid) next_state = S_LEN1;
            S_LEN1: begin
                if (rx_valid) begin
                    if (len_full == 16'd0 || {16'd0, len_full} > MAX_WORDS) begin
                        next_state = S_ERROR;
                        err_set    = 1'b1;
                        err_val    = 2'd1;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid && byte_cnt == 2'd3) begin
                    // A write still waiting for its ack means the RAM cannot keep up.
                    if (mem_stb && !mem_ack) begin
                        next_state = S_ERROR;
                        err_set    = 1'b1;
                        err_val    = 2'd2;
                    end else begin
                        issue_write = 1'b1;
                        if (word_idx == len - 16'd1) next_state = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == sum) begin
                        next_state = S_DRAIN;
                    end else begin
                        next_state = S_ERROR;
                        err_set    = 1'b1;
                        err_val    = 2'd3;
                    end
                end
            end
            S_DRAIN: if (!mem_stb || mem_ack) next_state = S_DONE;
            S_DONE:  next_state = S_DONE;
            S_ERROR: if (tx_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (timed_out && !rx_valid) begin
            next_state = S_ERROR;
            err_set    = 1'b1;
            err_val    = 2'd2;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            len_lo   <= '0;
            len      <= '0;
            word_idx <= '0;
            byte_cnt <= '0;
            word_buf <= '0;
            sum      <= '0;
            mem_stb  <= 1'b0;
            mem_adr  <= '0;
            mem_dat  <= '0;
            err_code <= 2'd0;
            tx_acked <= 1'b0;
        end else begin
            if (state == S_LEN0 && rx_valid) len_lo <= rx_data;
            if (state == S_LEN1 && rx_valid) begin
                len      <= len_full;
                word_idx <= '0;
                byte_cnt <= '0;
                sum      <= '0;
            end
            if (state == S_DATA && rx_valid) begin
                sum      <= sum + rx_data;
                byte_cnt <= byte_cnt + 2'd1;
                case (byte_cnt)
                    2'd0:    word_buf[7:0]   <= rx_data;
                    2'd1:    word_buf[15:8]  <= rx_data;
                    2'd2:    word_buf[23:16] <= rx_data;
                    default: ;
                endcase
            end
            // A new word issuing on an ack cycle replaces the completed request.
            if (issue_write) begin
                mem_stb  <= 1'b1;
                mem_dat  <= {rx_data, word_buf};
                mem_adr  <= BASE + ADDR_WIDTH'(word_idx);
                word_idx <= word_idx + 16'd1;
            end else if (mem_stb && mem_ack) begin
                mem_stb <= 1'b0;
            end
            if (state == S_IDLE && next_state == S_LEN0)
                err_code <= 2'd0;
            else if (err_set)
                err_code <= err_val;
            if (state == S_DONE && tx_ready) tx_acked <= 1'b1;
        end
    end

    assign tx_valid  = (state == S_ERROR) || (state == S_DONE && !tx_acked);
    assign tx_data   = (state == S_ERROR) ? NAK_BYTE : ((state == S_DONE) ? ACK_BYTE : 8'h00);
    assign cpu_rst_n = (state == S_DONE);
    assign done      = (state == S_DONE);
    assign busy      = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

endmodule
